// File: rtl/minisrc_datapath.sv
// Register-file datapath with shared bus, Y/Z holding registers, multi-op ALU and a
// built-in IDLE->LDY->ALU->WB sequencer. Optional macro R0_ZERO_EN hard-wires r0 to zero.
module minisrc_datapath #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NREGS = 16,
  localparam int unsigned AW = $clog2(NREGS)
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [AW-1:0]    cmd_rd,
  input  logic [AW-1:0]    cmd_ra,
  input  logic [AW-1:0]    cmd_rb,
  input  logic [WIDTH-1:0] cmd_imm,
  output logic             done,
  output logic [WIDTH-1:0] bus_out,
  output logic             flag_z,
  output logic             flag_c,
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  typedef enum logic [1:0] {S_IDLE, S_LDY, S_ALU, S_WB} state_t;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR  = 3'd3,
    OP_XOR = 3'd4, OP_MOV = 3'd5, OP_LDI = 3'd6, OP_NOP = 3'd7
  } op_t;

  typedef struct packed {
    op_t              op;
    logic [AW-1:0]    rd;
    logic [AW-1:0]    ra;
    logic [AW-1:0]    rb;
    logic [WIDTH-1:0] imm;
  } cmd_t;

  state_t           state, state_nxt;
  cmd_t             cmd_q;
  logic [WIDTH-1:0] regs [NREGS];
  logic [WIDTH-1:0] y_q, z_q;
  logic [WIDTH-1:0] rdata_a, rdata_b, bus;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH:0]   sum;
  logic             alu_c;
  logic             hs;
  logic             wr_en;
  logic             flag_op;

  // Register-file read ports (sequencer A/B and debug)
  always_comb begin
    rdata_a  = regs[cmd_q.ra];
    rdata_b  = regs[cmd_q.rb];
    dbg_data = regs[dbg_addr];
`ifdef R0_ZERO_EN
    if (cmd_q.ra == '0) rdata_a = '0;
    if (cmd_q.rb == '0) rdata_b = '0;
    if (dbg_addr == '0) dbg_data = '0;
`endif
  end

  // Single bus source per state
  always_comb begin
    bus = '0;
    case (state)
      S_LDY:   bus = rdata_a;
      S_ALU:   bus = (cmd_q.op == OP_LDI) ? cmd_q.imm : rdata_b;
      S_WB:    bus = z_q;
      default: bus = '0;
    endcase
  end

  assign bus_out = bus;

  // ALU: Y op bus; SUB uses Y + ~B + 1 so carry-out means no borrow
  always_comb begin
    sum     = '0;
    alu_res = z_q;
    alu_c   = 1'b0;
    case (cmd_q.op)
      OP_ADD: begin
        sum     = {1'b0, y_q} + {1'b0, bus};
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
      end
      OP_SUB: begin
        sum     = {1'b0, y_q} + {1'b0, ~bus} + (WIDTH+1)'(1);
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
      end
      OP_AND:  alu_res = y_q & bus;
      OP_OR:   alu_res = y_q | bus;
      OP_XOR:  alu_res = y_q ^ bus;
      OP_MOV:  alu_res = bus;
      OP_LDI:  alu_res = bus;
      default: alu_res = z_q;
    endcase
  end

  assign flag_op = (cmd_q.op == OP_ADD) || (cmd_q.op == OP_SUB) || (cmd_q.op == OP_AND) ||
                   (cmd_q.op == OP_OR)  || (cmd_q.op == OP_XOR);

  // Sequencer next state and write enable
  always_comb begin
    state_nxt = state;
    hs        = 1'b0;
    wr_en     = 1'b0;
    case (state)
      S_IDLE: begin
        hs = cmd_valid;
        if (cmd_valid) state_nxt = S_LDY;
      end
      S_LDY: state_nxt = S_ALU;
      S_ALU: state_nxt = S_WB;
      S_WB: begin
        state_nxt = S_IDLE;
        wr_en     = (cmd_q.op != OP_NOP);
`ifdef R0_ZERO_EN
        if (cmd_q.rd == '0) wr_en = 1'b0;
`endif
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state     <= S_IDLE;
      cmd_q     <= '0;
      y_q       <= '0;
      z_q       <= '0;
      flag_z    <= 1'b0;
      flag_c    <= 1'b0;
      done      <= 1'b0;
      cmd_ready <= 1'b1;
      for (int i = 0; i < int'(NREGS); i++) regs[i] <= '0;
    end else begin
      state     <= state_nxt;
      cmd_ready <= (state_nxt == S_IDLE);
      done      <= (state == S_WB);
      if (hs) begin
        cmd_q.op  <= op_t'(cmd_op);
        cmd_q.rd  <= cmd_rd;
        cmd_q.ra  <= cmd_ra;
        cmd_q.rb  <= cmd_rb;
        cmd_q.imm <= cmd_imm;
      end
      if (state == S_LDY) y_q <= bus;
      if (state == S_ALU) begin
        z_q <= alu_res;
        if (flag_op) begin
          flag_z <= (alu_res == '0);
          flag_c <= alu_c;
        end
      end
      if (wr_en) regs[cmd_q.rd] <= bus;
    end
  end

endmodule

// File: tb/tb_minisrc_datapath.sv
// Self-checking bench for minisrc_datapath: timeline scoreboard model compared every
// cycle, plus directed literal checks. Honours R0_ZERO_EN in the model.
module tb_minisrc_datapath;
  localparam int unsigned W  = 8;
  localparam int unsigned N  = 16;
  localparam int unsigned AW = 4;

  localparam bit [2:0] ADD = 3'd0, SUB = 3'd1, AND = 3'd2, OR = 3'd3,
                       XOR = 3'd4, MOV = 3'd5, LDI = 3'd6, NOP = 3'd7;

  logic          clock     = 1'b0;
  logic          clear     = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [2:0]    cmd_op    = '0;
  logic [AW-1:0] cmd_rd    = '0;
  logic [AW-1:0] cmd_ra    = '0;
  logic [AW-1:0] cmd_rb    = '0;
  logic [W-1:0]  cmd_imm   = '0;
  logic          done;
  logic [W-1:0]  bus_out;
  logic          flag_z, flag_c;
  logic [AW-1:0] dbg_addr;
  logic [W-1:0]  dbg_data;

  logic          sweep   = 1'b1;
  logic [AW-1:0] dbg_sel = '0;
  bit            started = 1'b0;
  int            checks  = 0;
  int            errors  = 0;

  // Model state: committed architectural view plus one in-flight command timeline
  bit [7:0] m_r [N];
  bit [7:0] m_z;
  bit       m_fz, m_fc, m_done, m_hs;
  bit       m_ready = 1'b1;
  bit       pend;
  int       cyc, p_issue;
  bit [2:0] p_op;
  bit [3:0] p_rd;
  bit [7:0] p_a, p_b, p_res;
  bit       p_fz, p_fc;

  int       cmp_d;
  bit [7:0] cmp_bus;

  minisrc_datapath #(.WIDTH(W), .NREGS(N)) dut (
    .clock(clock), .clear(clear), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb),
    .cmd_imm(cmd_imm), .done(done), .bus_out(bus_out), .flag_z(flag_z),
    .flag_c(flag_c), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clock = ~clock;

  assign dbg_addr = sweep ? AW'(cyc) : dbg_sel;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit [7:0] mread(input bit [3:0] a);
`ifdef R0_ZERO_EN
    if (a == 4'd0) return 8'h00;
`endif
    return m_r[a];
  endfunction

  task automatic alu_model(input bit [2:0] op, input bit [7:0] a, input bit [7:0] b,
                           input bit [7:0] z, output bit [7:0] r, output bit c);
    int s;
    c = 1'b0;
    case (op)
      ADD: begin s = int'(a) + int'(b); r = 8'(s); c = (s > 255); end
      SUB: begin r = 8'(int'(a) - int'(b)); c = (a >= b); end
      AND: r = a & b;
      OR:  r = a | b;
      XOR: r = a ^ b;
      MOV, LDI: r = b;
      default: r = z;
    endcase
  endtask

  // Model: handshake at edge n -> LDY/ALU/WB at offsets 0..2, commit+done at offset 3
  always @(posedge clock or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < int'(N); i++) m_r[i] = 8'h00;
      m_z = 8'h00; m_fz = 1'b0; m_fc = 1'b0;
      m_done = 1'b0; m_ready = 1'b1; pend = 1'b0;
    end else begin
      m_hs = (cmd_valid === 1'b1) && m_ready;
      cyc++;
      m_done = 1'b0;
      if (pend && cyc == p_issue + 2) begin
        m_z = p_res;
        if (p_op <= XOR) begin m_fz = p_fz; m_fc = p_fc; end
      end
      if (pend && cyc == p_issue + 3) begin
        if (p_op != NOP) begin
`ifdef R0_ZERO_EN
          if (p_rd != 4'd0) m_r[p_rd] = p_res;
`else
          m_r[p_rd] = p_res;
`endif
        end
        m_done = 1'b1;
        pend   = 1'b0;
      end
      if (m_hs) begin
        pend    = 1'b1;
        p_issue = cyc;
        p_op    = cmd_op;
        p_rd    = cmd_rd;
        p_a     = mread(cmd_ra);
        p_b     = (cmd_op == LDI) ? cmd_imm : mread(cmd_rb);
        alu_model(p_op, p_a, p_b, m_z, p_res, p_fc);
        p_fz    = (p_res == 8'h00);
      end
      m_ready = !pend;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clock) begin
    if (started) begin
      cmp_bus = 8'h00;
      if (pend) begin
        cmp_d = cyc - p_issue;
        case (cmp_d)
          0: cmp_bus = p_a;
          1: cmp_bus = p_b;
          2: cmp_bus = p_res;
          default: cmp_bus = 8'h00;
        endcase
      end
      chk("bus_out", int'(bus_out), int'(cmp_bus));
      chk("done", int'(done), int'(m_done));
      if (!clear) chk("cmd_ready", int'(cmd_ready), int'(m_ready));
      chk("flag_z", int'(flag_z), int'(m_fz));
      chk("flag_c", int'(flag_c), int'(m_fc));
      chk("dbg_data", int'(dbg_data), int'(mread(dbg_addr)));
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 10) begin @(negedge clock); #1; n++; end
    if (n >= 10) chk("ready_timeout", int'(cmd_ready), 1);
  endtask

  task automatic run(input bit [2:0] op, input bit [3:0] rd, input bit [3:0] ra,
                     input bit [3:0] rb, input bit [7:0] imm);
    int n;
    cmd_op = op; cmd_rd = rd; cmd_ra = ra; cmd_rb = rb; cmd_imm = imm;
    cmd_valid = 1'b1;
    wait_ready();
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    cmd_op = 3'($urandom); cmd_rd = 4'($urandom); cmd_ra = 4'($urandom);
    cmd_rb = 4'($urandom); cmd_imm = 8'($urandom);
    n = 0;
    do begin @(negedge clock); #1; n++; end while (done !== 1'b1 && n < 8);
    chk("done_latency", n, 4);
  endtask

  task automatic expect_reg(input bit [3:0] a, input bit [7:0] v);
    sweep = 1'b0; dbg_sel = a; #1;
    chk($sformatf("r%0d", a), int'(dbg_data), int'(v));
    sweep = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    time t [3];
    int  n;
    repeat (2) @(posedge clock);
    @(negedge clock); #1;
    clear = 1'b0; started = 1'b1;
    chk("reset_ready", int'(cmd_ready), 1);
    chk("reset_done", int'(done), 0);
    chk("reset_flags", int'({flag_z, flag_c}), 0);

    run(LDI, 1, 0, 0, 8'h05);
    run(LDI, 2, 0, 0, 8'h03);
    run(ADD, 3, 1, 2, 8'h00);
    expect_reg(3, 8'h08);
    chk("add_z", int'(flag_z), 0); chk("add_c", int'(flag_c), 0);

    run(LDI, 4, 0, 0, 8'hFF);
    run(LDI, 5, 0, 0, 8'h01);
    run(ADD, 6, 4, 5, 8'h00);
    expect_reg(6, 8'h00);
    chk("wrap_z", int'(flag_z), 1); chk("wrap_c", int'(flag_c), 1);
    run(SUB, 7, 5, 4, 8'h00);
    expect_reg(7, 8'h02);
    chk("sub_z", int'(flag_z), 0); chk("sub_c", int'(flag_c), 0);

    run(AND, 8, 4, 1, 8'h00);  expect_reg(8, 8'h05);
    run(OR, 9, 1, 2, 8'h00);   expect_reg(9, 8'h07);
    run(XOR, 10, 4, 1, 8'h00); expect_reg(10, 8'hFA);
    chk("xor_c", int'(flag_c), 0);

    run(ADD, 12, 4, 5, 8'h00);
    run(NOP, 4, 1, 2, 8'h00);
    expect_reg(4, 8'hFF);
    run(MOV, 11, 0, 3, 8'h00);
    expect_reg(11, 8'h08);
    chk("hold_z", int'(flag_z), 1); chk("hold_c", int'(flag_c), 1);

    run(ADD, 1, 1, 1, 8'h00);
    expect_reg(1, 8'h0A);

    // Back-to-back with cmd_valid held high; later fields change while busy
    cmd_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: begin cmd_op = ADD; cmd_rd = 14; cmd_ra = 1;  cmd_rb = 2; end
        1: begin cmd_op = SUB; cmd_rd = 15; cmd_ra = 14; cmd_rb = 5; end
        default: begin cmd_op = XOR; cmd_rd = 2; cmd_ra = 15; cmd_rb = 1; end
      endcase
      wait_ready();
      @(posedge clock); t[k] = $time; #1;
    end
    cmd_valid = 1'b0;
    n = 0;
    do begin @(negedge clock); #1; n++; end while (done !== 1'b1 && n < 8);
    chk("chain_done", n, 4);
    chk("hs_gap1", int'((t[1] - t[0]) / 10), 4);
    chk("hs_gap2", int'((t[2] - t[1]) / 10), 4);
    expect_reg(14, 8'h0D);
    expect_reg(15, 8'h0C);
    expect_reg(2, 8'h06);

    run(LDI, 0, 0, 0, 8'h77);
    run(MOV, 13, 0, 0, 8'h00);
`ifdef R0_ZERO_EN
    expect_reg(13, 8'h00);
`else
    expect_reg(13, 8'h77);
`endif

    // Clear pulsed during the ALU step of ADD r2,r1,r1
    run(LDI, 1, 0, 0, 8'hAA);
    cmd_op = ADD; cmd_rd = 2; cmd_ra = 1; cmd_rb = 1; cmd_valid = 1'b1;
    wait_ready();
    @(posedge clock); #1; cmd_valid = 1'b0;
    @(negedge clock); @(negedge clock); #1;
    clear = 1'b1;
    cmd_op = LDI; cmd_rd = 3; cmd_imm = 8'h55; cmd_valid = 1'b1;
    repeat (2) @(negedge clock);
    #1; cmd_valid = 1'b0; clear = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock); #1;
      chk("no_done_after_clear", int'(done), 0);
    end
    for (int i = 0; i < int'(N); i++) expect_reg(4'(i), 8'h00);
    chk("clear_ready", int'(cmd_ready), 1);
    chk("clear_flags", int'({flag_z, flag_c}), 0);

    run(LDI, 3, 0, 0, 8'h5A);
    run(ADD, 4, 3, 3, 8'h00);
    expect_reg(4, 8'hB4);
    chk("recover_c", int'(flag_c), 0);

    repeat (3) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/minisrc_datapath.md
Name: minisrc_datapath

Overview:
Parametrised successor to the single-adder 8-bit datapath. Contains an NREGS x WIDTH register file, a shared bus, Y and Z holding registers and a multi-op ALU. A built-in 3-step micro-sequencer runs one register-to-register command per handshake, so the bus is driven by exactly one source per cycle. Sits between the instruction-control unit (command source) and the rest of the CPU.

Parameters:
WIDTH, 8, datapath and register width in bits (>=4)
NREGS, 16, number of general registers (power of 2, >=2); AW = clog2(NREGS)

Ports:
clock  in  1  system clock, rising edge
clear  in  1  reset, asynchronous, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  block can accept a command (high only in IDLE)
cmd_op  in  3  operation code (see Behaviour)
cmd_rd  in  AW  destination register
cmd_ra  in  AW  source A register
cmd_rb  in  AW  source B register
cmd_imm  in  WIDTH  immediate operand
done  out  1  one-cycle pulse: command retired
bus_out  out  WIDTH  current bus value (observability)
flag_z  out  1  zero flag from the last ALU op
flag_c  out  1  carry/borrow flag from the last ALU op
dbg_addr  in  AW  debug read address
dbg_data  out  WIDTH  combinational R[dbg_addr]

Behaviour:
- Reset (clear high, async): state=IDLE; all R[i], Y, Z, latched cmd fields = 0; flag_z=0, flag_c=0, done=0; cmd_ready=1 once clear is released. Commands offered while clear is high are ignored.
- Reset mid-command: aborts the command immediately, with no register write and no done.
- FSM states: IDLE -> LDY -> ALU -> WB -> IDLE.
- IDLE: cmd_ready=1. A handshake (cmd_valid & cmd_ready) on an edge latches op/rd/ra/rb/imm and moves to LDY. bus_out=0.
- LDY: bus=R[ra]; Y<=bus.
- ALU: bus=R[rb], except for LDI, where bus=imm. Z<=f(Y,bus), truncated to WIDTH.
- WB: bus=Z; R[rd]<=bus at the end of the cycle (no write for op 7). Next state is IDLE; done is registered high for the following cycle.
- Timing: handshake at edge n; R[rd] is updated at edge n+3; done=1 and cmd_ready=1 during cycle n+3..n+4. A new command may be accepted in the done cycle (back-to-back throughput = 1 command per 4 cycles).
- Ops:
  - 0 ADD: Y+B, C = carry-out.
  - 1 SUB: Y-B computed as Y+~B+1; C = carry-out (1 = no borrow).
  - 2 AND, 3 OR, 4 XOR: C is cleared to 0.
  - 5 MOV: Z=R[rb].
  - 6 LDI: Z=imm.
  - 7 NOP: Z unchanged, no writeback, still pulses done.
- Flags: updated in the ALU state for ops 0-4 only; flag_z = (result==0). All other ops hold both flags.
- Aliasing: rd/ra/rb may be equal; reads always see values from before WB (e.g. ADD r1,r1,r1 doubles r1).
- dbg_data: asynchronous read. During WB it returns the old R[rd]; the new value appears after the edge.
- cmd_* values are ignored outside the handshake cycle.

Optional Feature:
R0_ZERO_EN: when defined, R[0] reads as 0 on the bus and on dbg_data, and writes to r0 are discarded (done still pulses). When undefined, r0 is an ordinary register.

Test Plan:
- Reset: assert clear mid-sim -> all dbg_data reads 0x00, cmd_ready=1, done=0, flags=0.
- LDI r1=0x05, LDI r2=0x03, ADD r3,r1,r2 -> dbg r3=0x08, flag_z=0, flag_c=0; done exactly 4 cycles after each handshake.
- LDI r4=0xFF, LDI r5=0x01, ADD r6,r4,r5 -> r6=0x00, flag_z=1, flag_c=1; SUB r7,r5,r4 -> r7=0x02, flag_c=0.
- cmd_valid held high for 3 commands -> handshakes exactly 4 cycles apart; cmd_ready low in LDY/ALU/WB; bus_out shows R[ra], R[rb]/imm, Z in order.
- LDI r1=0xAA, then clear pulsed during ALU of ADD r2,r1,r1 -> r2 stays 0x00, no done, r1=0x00.
- With R0_ZERO_EN: LDI r0=0x77, MOV r1,r0 -> r1=0x00; without the macro, r1=0x77.
